// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_arbiter
// Brief    : Round-robin arbiter that shares one floating-point add/sub unit
//            (addsub) between NREQ requesters. The winner's operands are
//            latched, add_start is pulsed, the operands are held until
//            add_done, and the result and overflow flag go back to the winner.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NREQ    - number of requesters (2..8)
//   IDW     - grant index width, 2**IDW >= NREQ
//   TIMEOUT - WAIT watchdog limit in cycles (timeout build only, 1..255)
// Ports
//   clk, n_rst                     - clock, synchronous active-low reset
//   req_valid/req_mode [NREQ]      - per-requester request and mode (1 = sub)
//   req_op1/req_op2 [32*NREQ]      - packed operands, requester i at [32i+:32]
//   req_ready [NREQ]               - one-hot accept pulse
//   rsp_valid [NREQ]               - one-hot response pulse
//   rsp_result/overflow/error      - response payload, valid with rsp_valid
//   busy                           - arbiter is not idle
//   add_start/mode/op1/op2         - command to addsub
//   add_result/add_done/overflow   - completion from addsub
// Build option
//   FP_ADDSUB_ARB_TIMEOUT_EN - adds an 8-bit WAIT watchdog; on expiry the
//   requester receives rsp_error = 1 with a quiet-NaN result. Without it
//   WAIT waits indefinitely and rsp_error is tied low.
// ============================================================================
module fp_addsub_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_op1,
   input  logic [32*NREQ-1:0]   req_op2,
   input  logic [NREQ-1:0]      req_mode,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_result,
   output logic                 rsp_overflow,
   output logic                 rsp_error,
   output logic                 busy,
   output logic                 add_start,
   output logic                 mode,
   output logic [31:0]          op1,
   output logic [31:0]          op2,
   input  logic [31:0]          add_result,
   input  logic                 add_done,
   input  logic                 add_overflow
);

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_issue = 2'd1;
   localparam logic [1:0]  c_st_wait  = 2'd2;
   localparam logic [1:0]  c_st_resp  = 2'd3;
   localparam logic [31:0] c_qnan     = 32'h7FC0_0000;
   localparam int          c_vw       = 2**IDW;

   if ((NREQ < 2) || (NREQ > 8) || ((2**IDW) < NREQ) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_param_check
      $error("fp_addsub_arbiter: illegal NREQ/IDW/TIMEOUT combination");
   end

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  r_grant;
   logic [IDW-1:0]  w_winner;
   logic [IDW:0]    w_scan;
   logic [c_vw-1:0] w_valid_ext;
   logic            w_found;
   logic            w_accept;
   logic            w_timeout;
   logic [31:0]     w_sel_op1;
   logic [31:0]     w_sel_op2;
   logic            w_sel_mode;
   logic [31:0]     r_op1;
   logic [31:0]     r_op2;
   logic            r_mode;
   logic [31:0]     r_result;
   logic            r_overflow;

   // Round-robin scan: first set request starting just above the last
   // winner. The valid vector is padded to 2**IDW so the IDW-bit scan
   // index can address it directly.
   always_comb begin
      w_valid_ext            = '0;
      w_valid_ext[NREQ-1:0]  = req_valid;
      w_found                = 1'b0;
      w_winner               = '0;
      w_scan                 = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_scan >= (IDW+1)'(NREQ)) begin
            w_scan = w_scan - (IDW+1)'(NREQ);
         end
         if (!w_found && w_valid_ext[w_scan[IDW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_scan[IDW-1:0];
         end
      end
   end

   // No acceptance while reset is asserted: the latches are being cleared,
   // so an accept pulse would hand the requester a transaction that is lost.
   assign w_accept = (r_state == c_st_idle) && n_rst && w_found;

   always_comb begin
      w_sel_op1  = '0;
      w_sel_op2  = '0;
      w_sel_mode = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_winner == IDW'(k)) begin
            w_sel_op1  = req_op1[32*k +: 32];
            w_sel_op2  = req_op2[32*k +: 32];
            w_sel_mode = req_mode[k];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_accept) w_state_nxt = c_st_issue;
         c_st_issue: w_state_nxt = c_st_wait;
         c_st_wait:  if (add_done || w_timeout) w_state_nxt = c_st_resp;
         c_st_resp:  w_state_nxt = c_st_idle;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   // Output logic. rsp_valid is suppressed during reset so an aborted
   // transaction never produces a response.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_ready[k] = w_accept && (w_winner == IDW'(k));
         rsp_valid[k] = n_rst && (r_state == c_st_resp) && (r_grant == IDW'(k));
      end
      add_start = (r_state == c_st_issue);
      busy      = (r_state != c_st_idle);
   end

   // Operand, grant and response registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_rr_ptr   <= IDW'(NREQ-1);
         r_grant    <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_mode     <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_grant <= w_winner;
            r_op1   <= w_sel_op1;
            r_op2   <= w_sel_op2;
            r_mode  <= w_sel_mode;
         end
         if (r_state == c_st_wait) begin
            // A completion in the expiry cycle still wins over the timeout.
            if (add_done) begin
               r_result   <= add_result;
               r_overflow <= add_overflow;
            end else if (w_timeout) begin
               r_result   <= c_qnan;
               r_overflow <= 1'b0;
            end
         end
         if (r_state == c_st_resp) begin
            r_rr_ptr <= r_grant;
         end
      end
   end

`ifdef FP_ADDSUB_ARB_TIMEOUT_EN
   logic [7:0] r_wdog;
   logic       r_rsp_error;

   // Cleared in ISSUE so it reads 0 in the first WAIT cycle; expiry is the
   // cycle it shows TIMEOUT-1, putting RESP exactly TIMEOUT cycles after
   // WAIT was entered.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_wdog      <= '0;
         r_rsp_error <= 1'b0;
      end else begin
         if (r_state == c_st_issue) begin
            r_wdog <= '0;
         end else if (r_state == c_st_wait) begin
            r_wdog <= r_wdog + 8'd1;
         end
         if (r_state == c_st_wait) begin
            if (add_done) begin
               r_rsp_error <= 1'b0;
            end else if (w_timeout) begin
               r_rsp_error <= 1'b1;
            end
         end
      end
   end

   assign w_timeout = (r_state == c_st_wait) && (r_wdog == 8'(TIMEOUT-1));
   assign rsp_error = r_rsp_error;
`else
   assign w_timeout = 1'b0;
   assign rsp_error = 1'b0;
`endif

   assign op1          = r_op1;
   assign op2          = r_op2;
   assign mode         = r_mode;
   assign rsp_result   = r_result;
   assign rsp_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_arbiter
// Brief    : Self-checking bench for fp_addsub_arbiter with a stub addsub
//            unit, a transaction-level reference model and directed plus
//            randomized requester traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_arbiter;

   localparam int NREQ    = 4;
   localparam int IDW     = 3;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              n_rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [32*NREQ-1:0] req_op1;
   logic [32*NREQ-1:0] req_op2;
   logic [NREQ-1:0]   req_mode;
   logic [NREQ-1:0]   rsp_valid;
   logic [31:0]       rsp_result;
   logic              rsp_overflow;
   logic              rsp_error;
   logic              busy;
   logic              add_start;
   logic              mode;
   logic [31:0]       op1;
   logic [31:0]       op2;
   logic [31:0]       add_result;
   logic              add_done;
   logic              add_overflow;

   fp_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
      .busy(busy), .add_start(add_start), .mode(mode),
      .op1(op1), .op2(op2),
      .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow)
   );

   always #5 clk = ~clk;

   int cyc_p = 0;
   always @(posedge clk) cyc_p <= cyc_p + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc_p, act, exp);
      end
   endtask

   // Stand-in addsub behaviour: exact IEEE results for the documented
   // operand pairs, an integer mix for everything else.
   function automatic logic [31:0] fp_fn(input logic [31:0] a, input logic [31:0] b, input logic m);
      if (a == 32'h4000_0000 && b == 32'h3F80_0000 && !m) return 32'h4040_0000;
      if (a == 32'h4040_0000 && b == 32'h3F80_0000 &&  m) return 32'h4000_0000;
      return m ? (a - b) : (a + b);
   endfunction

   function automatic logic fp_ovf(input logic [31:0] a, input logic [31:0] b, input logic m);
      if ((a == 32'h4000_0000 || a == 32'h4040_0000) && b == 32'h3F80_0000) return 1'b0;
      return ^(a[7:0] ^ b[7:0]) ^ m;
   endfunction

   // ---------------- stub addsub ----------------
   int          stub_lat    = 1;
   bit          stub_stall  = 1'b0;
   bit          stub_glitch = 1'b0;
   int          stub_pending;
   logic [31:0] s_op1, s_op2;
   logic        s_mode;

   initial begin
      add_done = 1'b0; add_result = '0; add_overflow = 1'b0; stub_pending = 0;
      s_op1 = '0; s_op2 = '0; s_mode = 1'b0;
      forever begin
         @(posedge clk); #1;
         add_done     = 1'b0;
         add_result   = $urandom;
         add_overflow = 1'($urandom_range(0, 1));
         if (!busy) begin
            stub_pending = 0;
            if (stub_glitch && $urandom_range(0, 7) == 0) add_done = 1'b1;
         end else if (add_start) begin
            s_op1 = op1; s_op2 = op2; s_mode = mode;
            stub_pending = stub_lat;
            // spurious completion in the ISSUE cycle must be ignored
            if (stub_glitch && $urandom_range(0, 1) == 1) add_done = 1'b1;
         end else if (stub_pending > 0) begin
            stub_pending--;
            if (stub_pending == 0 && !stub_stall) begin
               add_done     = 1'b1;
               add_result   = fp_fn(s_op1, s_op2, s_mode);
               add_overflow = fp_ovf(s_op1, s_op2, s_mode);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   bit              model_en = 1'b0;
   bit              m_active = 1'b0;
   bit              m_post_rst = 1'b0;
   bit              m_err;
   int              m_rr = NREQ - 1;
   int              m_g, m_acc, m_rsp_cyc;
   logic [31:0]     m_op1, m_op2;
   logic            m_mode;
   logic [NREQ-1:0] rdy_seen = '0;

   function automatic int rr_pick(input int rr, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_step();
      int              c;
      int              w;
      logic [NREQ-1:0] e_ready, e_rsp;
      c = cyc_p;
      w = rr_pick(m_rr, req_valid);
      e_ready = (!m_active && n_rst && w >= 0) ? NREQ'(1 << w) : '0;
      e_rsp   = (m_active && n_rst && c == m_rsp_cyc) ? NREQ'(1 << m_g) : '0;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("busy", 32'(busy), 32'(m_active));
      chk("add_start", 32'(add_start), 32'(m_active && c == m_acc + 1));
      if (m_active && c > m_acc) begin
         chk("op1_hold", op1, m_op1);
         chk("op2_hold", op2, m_op2);
         chk("mode_hold", 32'(mode), 32'(m_mode));
      end
      if (e_rsp != '0) begin
         chk("rsp_result", rsp_result, m_err ? 32'h7FC0_0000 : fp_fn(m_op1, m_op2, m_mode));
         chk("rsp_overflow", 32'(rsp_overflow), 32'(m_err ? 1'b0 : fp_ovf(m_op1, m_op2, m_mode)));
         chk("rsp_error", 32'(rsp_error), 32'(m_err));
      end
      if (m_post_rst) begin
         chk("rst_op1", op1, 32'h0);
         chk("rst_mode", 32'(mode), 32'h0);
         chk("rst_result", rsp_result, 32'h0);
         chk("rst_flags", {30'h0, rsp_overflow, rsp_error}, 32'h0);
         m_post_rst = 1'b0;
      end
      // advance to the next cycle
      if (!n_rst) begin
         m_active = 1'b0; m_rr = NREQ - 1; m_post_rst = 1'b1;
      end else if (!m_active) begin
         if (w >= 0) begin
            m_active = 1'b1; m_g = w; m_acc = c; m_rsp_cyc = -1;
            m_op1 = req_op1[32*w +: 32]; m_op2 = req_op2[32*w +: 32]; m_mode = req_mode[w];
         end
      end else if (c == m_rsp_cyc) begin
         m_active = 1'b0; m_rr = m_g;
      end else if (m_rsp_cyc < 0 && c >= m_acc + 2) begin
         if (add_done) begin
            m_rsp_cyc = c + 1; m_err = 1'b0;
         end
`ifdef FP_ADDSUB_ARB_TIMEOUT_EN
         else if (c == m_acc + 1 + TIMEOUT) begin
            m_rsp_cyc = c + 1; m_err = 1'b1;
         end
`endif
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (model_en) model_step();
         rdy_seen = req_ready;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic reset_dut(input int n);
      n_rst = 1'b0; req_valid = '0;
      repeat (n) tick();
      n_rst = 1'b1;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic m);
      req_op1[32*i +: 32] = a; req_op2[32*i +: 32] = b; req_mode[i] = m;
   endtask

   task automatic wait_ready(output int idx, output int at);
      bit found;
      found = 1'b0; idx = -1; at = -1;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            found = 1'b1; at = cyc_p;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
         end
      end
      if (!found) begin
         n_checks++; n_errors++;
         $display("FAIL wait_ready: got no req_ready expected one within 60 cycles");
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) begin
         n_checks++; n_errors++;
         $display("FAIL wait_idle: got busy=1 expected 0 within 60 cycles");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   // ---------------- test sequence ----------------
   int g, t, g_acc[5], t_acc[5], t_r;

   initial begin
      n_rst = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; req_mode = '0;
      @(posedge clk); @(posedge clk); #1;
      model_en = 1'b1;
      reset_dut(2);

      // single add from requester 0
      stub_lat = 1;
      set_ops(0, 32'h4000_0000, 32'h3F80_0000, 1'b0);
      req_valid = 4'b0001;
      wait_ready(g, t);
      chk("t1_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = '0;
      @(negedge clk); chk("t1_start", 32'(add_start), 32'h1);
      @(negedge clk); chk("t1_wait_no_rsp", 32'(rsp_valid), 32'h0);
      @(negedge clk); chk("t1_rsp", 32'(rsp_valid), 32'h1);
      chk("t1_result", rsp_result, 32'h4040_0000);
      chk("t1_ovf", 32'(rsp_overflow), 32'h0);

      // subtract from requester 2, operands scrambled after acceptance
      tick();
      set_ops(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
      req_valid = 4'b0100;
      wait_ready(g, t);
      chk("t2_grant", 32'(g), 32'd2);
      tick(); req_valid = '0; set_ops(2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t2_op1", op1, 32'h4040_0000);
         chk("t2_mode", 32'(mode), 32'h1);
      end
      chk("t2_rsp", 32'(rsp_valid), 32'h4);
      chk("t2_result", rsp_result, 32'h4000_0000);

      // full contention
      tick(); reset_dut(2);
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) wait_ready(g_acc[n], t_acc[n]);
      for (int n = 0; n < 5; n++) begin
         chk("t3_order", 32'(g_acc[n]), 32'(n % 4));
         if (n > 0) chk("t3_spacing", 32'(t_acc[n] - t_acc[n-1]), 32'd4);
      end
      tick(); req_valid = '0;
      wait_idle();

      // withdraw of requester 1, late operand change by requester 3
      tick(); reset_dut(2);
      set_ops(0, 32'h1111_0000, 32'h0000_2222, 1'b0);
      set_ops(1, 32'h3333_0000, 32'h0000_4444, 1'b1);
      set_ops(3, 32'h4000_0000, 32'h3F80_0000, 1'b0);
      req_valid = 4'b1011;
      wait_ready(g, t);
      chk("t4_first", 32'(g), 32'd0);
      tick(); req_valid[0] = 1'b0;
      tick(); req_valid[1] = 1'b0;
      wait_ready(g, t);
      chk("t4_second", 32'(g), 32'd3);
      tick(); req_valid[3] = 1'b0; set_ops(3, 32'hFFFF_FFFF, 32'h7F7F_7F7F, 1'b1);
      t_r = -1;
      for (int k = 0; k < 10 && t_r < 0; k++) begin
         @(negedge clk);
         if (rsp_valid != '0) t_r = cyc_p;
      end
      chk("t4_rsp", 32'(rsp_valid), 32'h8);
      chk("t4_result", rsp_result, 32'h4040_0000);

      // reset in the middle of WAIT
      tick(); reset_dut(2);
      req_valid = 4'b0010;
      wait_ready(g, t);
      tick(); req_valid = '0;
      wait_idle();
      stub_stall = 1'b1;
      tick(); req_valid = 4'b0100;
      wait_ready(g, t);
      chk("t5_grant", 32'(g), 32'd2);
      tick(); req_valid = '0;
      tick();
      tick(); n_rst = 1'b0;
      tick(); n_rst = 1'b1;
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_rsp", 32'(rsp_valid), 32'h0);
      chk("t5_op1", op1, 32'h0);
      stub_stall = 1'b0;
      tick(); req_valid = 4'b1111;
      wait_ready(g, t);
      chk("t5_after_rst_grant", 32'(g), 32'd0);
      tick(); req_valid = '0;
      wait_idle();

      // addsub that never completes
      stub_stall = 1'b1;
      tick(); set_ops(0, 32'h0102_0304, 32'h0506_0708, 1'b0); req_valid = 4'b0001;
      wait_ready(g, t);
      tick(); req_valid = '0;
`ifdef FP_ADDSUB_ARB_TIMEOUT_EN
      t_r = -1;
      for (int k = 0; k < 40 && t_r < 0; k++) begin
         @(negedge clk);
         if (rsp_valid != '0) t_r = cyc_p;
      end
      chk("t6_latency", 32'(t_r - t), 32'(2 + TIMEOUT));
      chk("t6_error", 32'(rsp_error), 32'h1);
      chk("t6_result", rsp_result, 32'h7FC0_0000);
      chk("t6_ovf", 32'(rsp_overflow), 32'h0);
      stub_stall = 1'b0;
`else
      repeat (30) @(negedge clk);
      chk("t6_busy_stuck", 32'(busy), 32'h1);
      chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
      stub_stall = 1'b0;
      tick(); reset_dut(2);
`endif

      // randomized traffic
      stub_glitch = 1'b1;
      for (int n = 0; n < 800; n++) begin
         tick();
         stub_lat = $urandom_range(1, 3);
         for (int i = 0; i < NREQ; i++) begin
            if (rdy_seen[i]) begin
               set_ops(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
               req_valid[i] = ($urandom_range(0, 3) == 0);
            end else if (req_valid[i]) begin
               if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               set_ops(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
               req_valid[i] = 1'b1;
            end
         end
      end
      tick(); req_valid = '0;
      wait_idle();
      stub_glitch = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
